// File: rtl/fc_pkg.sv
// Shared definitions for the fc APB master: FSM state encoding and fc control register offsets.
// Pure declarations, no latency or backpressure of its own.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_GAP    = 3'd3,
        ST_RESP   = 3'd4
    } fc_state_e;

    // fc control block register map, byte offsets on the APB bus
    localparam logic [31:0] FC_REG_COMMAND     = 32'h0000_0000;
    localparam logic [31:0] FC_REG_SIZE        = 32'h0000_0004;
    localparam logic [31:0] FC_REG_START       = 32'h0000_0008;
    localparam logic [31:0] FC_REG_DONE        = 32'h0000_000C;
    localparam logic [31:0] FC_REG_CLK_COUNTER = 32'h0000_0010;
    localparam logic [31:0] FC_REG_MAX_INDEX   = 32'h0000_0014;

    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/fc_apb_master.sv
// APB initiator executing one read/write/poll command at a time, with bounded polling.
// Latency: accept at N, SETUP at N+1, ACCESS from N+2, response the cycle after the final completion.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, APB waits on PREADY.
module fc_apb_master #(
    parameter int DATA_W    = 32,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_poll,
    input  logic [DATA_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    import fc_pkg::*;

    localparam int CNT_W = $clog2(MAX_POLLS + 1);

    fc_state_e              state;
    fc_state_e              state_nxt;
    logic [DATA_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      mask_q;
    logic                   write_q;
    logic                   poll_q;
    logic [CNT_W-1:0]       poll_cnt;
    logic [CNT_W-1:0]       poll_cnt_inc;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic [DATA_W-1:0]      rdata_q;
    logic                   err_q;
    logic                   timeout_q;
    logic                   complete;
    logic                   matched;
    logic                   at_limit;
    logic                   accept;

    assign complete     = (state == ST_ACCESS) && PREADY;
    assign matched      = |(PRDATA & mask_q);
    assign poll_cnt_inc = poll_cnt + CNT_W'(1);
    assign at_limit     = (poll_cnt_inc == CNT_W'(MAX_POLLS));
    assign accept       = (state == ST_IDLE) && cmd_valid;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    // error, single read/write, match or exhausted budget all finish the command
                    if (PSLVERR || !poll_q || matched || at_limit) begin
                        state_nxt = ST_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_CNT_W'(POLL_GAP - 1)) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            write_q   <= 1'b0;
            poll_q    <= 1'b0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= cmd_addr;
                wdata_q  <= cmd_wdata;
                mask_q   <= cmd_mask;
                write_q  <= cmd_write;
                poll_q   <= cmd_poll & ~cmd_write;
                poll_cnt <= '0;
            end
            if (complete) begin
                rdata_q   <= PRDATA;
                err_q     <= PSLVERR;
                timeout_q <= poll_q && !PSLVERR && !matched && at_limit;
                poll_cnt  <= poll_cnt_inc;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_CNT_W'(1) : '0;
        end
    end

    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign PWRITE      = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fc_apb_master.sv
// Bench for fc_apb_master: a per-cycle expectation timeline is built from the command rules,
// then replayed against the DUT with every cycle's outputs compared.
module tb_fc_apb_master;
    localparam int DW   = 32;
    localparam int GAP  = 4;
    localparam int MAXP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [DW-1:0] cmd_addr, cmd_wdata, cmd_mask;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [DW-1:0] PADDR, PWDATA, PRDATA;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    always #5 clk = ~clk;

    fc_apb_master #(.DATA_W(DW), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_poll(cmd_poll),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // one record per clock cycle: inputs to apply and outputs required
    typedef struct {
        bit          rst;
        bit          cv, cw, cp;
        logic [31:0] ca, cwd, cm;
        bit          pready, pslverr, rrdy;
        logic [31:0] prdata;
        bit          zero;
        bit          e_crdy, e_psel, e_pen, e_rv, e_write, e_err, e_to;
        logic [31:0] e_addr, e_wdata, e_rdata;
    } rec_t;

    rec_t        q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] rd_data [MAXP];
    bit          rd_err  [MAXP];
    int          rd_wait [MAXP];
    int          resp_delay;
    int          last_a, last_n, last_rsp_off, last_acc, last_gap, last_setup;
    bit          last_err, last_to;
    logic [31:0] last_rdata;

    function automatic rec_t junk_rec();
        rec_t r;
        r.rst = 0; r.cv = 1'($urandom % 2); r.cw = 1'($urandom % 2); r.cp = 1'($urandom % 2);
        r.ca = $urandom; r.cwd = $urandom; r.cm = $urandom;
        r.pready = 1'($urandom % 2); r.pslverr = 1'($urandom % 2); r.rrdy = 1'($urandom % 2);
        r.prdata = $urandom;
        r.zero = 0; r.e_crdy = 0; r.e_psel = 0; r.e_pen = 0; r.e_rv = 0;
        r.e_write = 0; r.e_err = 0; r.e_to = 0;
        r.e_addr = 0; r.e_wdata = 0; r.e_rdata = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic clear_reads();
        for (int j = 0; j < MAXP; j++) begin
            rd_data[j] = 0; rd_err[j] = 0; rd_wait[j] = 0;
        end
        resp_delay = 0;
    endtask

    task automatic add_idle();
        rec_t r;
        r = junk_rec(); r.cv = 0; r.e_crdy = 1;
        q.push_back(r);
    endtask

    task automatic add_cmd(input bit w, input bit p, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] mask);
        rec_t r;
        bit   err, to;
        int   n;
        r = junk_rec();
        r.cv = 1; r.cw = w; r.cp = p; r.ca = addr; r.cwd = wd; r.cm = mask; r.e_crdy = 1;
        q.push_back(r);
        last_a = q.size() - 1;
        // how many transfers the command takes and how it ends
        err = 0; to = 0; n = 0;
        for (int j = 0; j < MAXP; j++) begin
            n = j + 1;
            if (rd_err[j]) begin err = 1; break; end
            if (w || !p) break;
            if ((rd_data[j] & mask) != 0) break;
            if (n == MAXP) begin to = 1; break; end
        end
        last_gap = 0; last_acc = 0; last_setup = 0;
        for (int j = 0; j < n; j++) begin
            r = junk_rec(); r.e_psel = 1; r.e_addr = addr; r.e_wdata = wd; r.e_write = w;
            q.push_back(r); last_setup++;
            for (int k = 0; k <= rd_wait[j]; k++) begin
                r = junk_rec(); r.e_psel = 1; r.e_pen = 1;
                r.e_addr = addr; r.e_wdata = wd; r.e_write = w;
                r.pready = (k == rd_wait[j]);
                if (k == rd_wait[j]) begin r.prdata = rd_data[j]; r.pslverr = rd_err[j]; end
                q.push_back(r); last_acc++;
            end
            if (j < n - 1) begin
                for (int k = 0; k < GAP; k++) begin
                    r = junk_rec(); q.push_back(r); last_gap++;
                end
            end
        end
        last_rsp_off = q.size() - last_a;
        for (int k = 0; k <= resp_delay; k++) begin
            r = junk_rec(); r.e_rv = 1;
            r.e_rdata = rd_data[n-1]; r.e_err = err; r.e_to = to;
            r.rrdy = (k == resp_delay);
            q.push_back(r);
        end
        last_n = n; last_err = err; last_to = to; last_rdata = rd_data[n-1];
    endtask

    task automatic add_reset_rec(input bit rst_v, input bit crdy);
        rec_t r;
        r = junk_rec(); r.rst = rst_v; r.zero = 1; r.e_crdy = crdy;
        if (!rst_v) r.cv = 0;
        q.push_back(r);
    endtask

    task automatic drive(input rec_t r);
        rst = r.rst; cmd_valid = r.cv; cmd_write = r.cw; cmd_poll = r.cp;
        cmd_addr = r.ca; cmd_wdata = r.cwd; cmd_mask = r.cm;
        PREADY = r.pready; PRDATA = r.prdata; PSLVERR = r.pslverr; rsp_ready = r.rrdy;
    endtask

    task automatic check_rec(input rec_t r);
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, r.e_crdy});
        if (r.zero) begin
            chk("rst_psel", {31'b0, PSEL}, 0);
            chk("rst_penable", {31'b0, PENABLE}, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_pwdata", PWDATA, 0);
            chk("rst_pwrite", {31'b0, PWRITE}, 0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_flags", {30'b0, rsp_err, rsp_timeout}, 0);
        end else begin
            chk("psel", {31'b0, PSEL}, {31'b0, r.e_psel});
            chk("penable", {31'b0, PENABLE}, {31'b0, r.e_pen});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, r.e_rv});
            if (r.e_psel) begin
                chk("paddr", PADDR, r.e_addr);
                chk("pwrite", {31'b0, PWRITE}, {31'b0, r.e_write});
                chk("pwdata", PWDATA, r.e_wdata);
            end
            if (r.e_rv) begin
                chk("rsp_rdata", rsp_rdata, r.e_rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.e_err});
                chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, r.e_to});
            end
        end
    endtask

    initial begin
        rec_t r;
        logic [31:0] m;
        int keep;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_poll = 0;
        cmd_addr = 0; cmd_wdata = 0; cmd_mask = 0;
        PREADY = 0; PRDATA = 0; PSLVERR = 0; rsp_ready = 0;

        repeat (3) add_reset_rec(1, 0);
        add_reset_rec(0, 1);

        // single write, zero wait states
        clear_reads(); rd_data[0] = $urandom;
        add_cmd(1, 0, 32'h0000_0000, 32'h0000_0001, 32'h0);
        chk("pin_write_rsp_offset", last_rsp_off, 3);
        chk("pin_write_err", {31'b0, last_err}, 0);

        // read with three wait states
        clear_reads(); rd_wait[0] = 3; rd_data[0] = 32'h0000_0123; resp_delay = 2;
        add_cmd(0, 0, 32'h0000_0010, 32'h0, 32'h0);
        chk("pin_read_access_cycles", last_acc, 4);
        chk("pin_read_rdata", last_rdata, 32'h123);

        // poll matching on the third read
        clear_reads(); rd_data[2] = 32'h1;
        add_cmd(0, 1, 32'h0000_0004, 32'h0, 32'h1);
        chk("pin_poll_setups", last_setup, 3);
        chk("pin_poll_gap_cycles", last_gap, 8);
        chk("pin_poll_rdata", last_rdata, 32'h1);
        chk("pin_poll_timeout", {31'b0, last_to}, 0);

        // poll never matching
        clear_reads(); add_idle();
        add_cmd(0, 1, 32'h0000_0004, 32'h0, 32'h1);
        chk("pin_timeout_transfers", last_n, MAXP);
        chk("pin_timeout_flag", {31'b0, last_to}, 1);

        // slave error on second poll read
        clear_reads(); rd_err[1] = 1;
        add_cmd(0, 1, 32'h0000_0004, 32'h0, 32'h1);
        chk("pin_err_transfers", last_n, 2);
        chk("pin_err_flag", {31'b0, last_err}, 1);

        // match together with slave error
        clear_reads(); rd_data[0] = 32'h1; rd_err[0] = 1;
        add_cmd(0, 1, 32'h0000_0008, 32'h0, 32'h1);
        chk("pin_match_err_timeout", {31'b0, last_to}, 0);

        // match on the last allowed read
        clear_reads(); rd_data[MAXP-1] = 32'h8;
        add_cmd(0, 1, 32'h0000_000C, 32'h0, 32'h8);
        chk("pin_match_limit_n", last_n, MAXP);
        chk("pin_match_limit_timeout", {31'b0, last_to}, 0);

        // reset in the middle of an ACCESS phase
        clear_reads(); rd_wait[0] = 6;
        add_cmd(0, 0, 32'h0000_0020, 32'h0, 32'h0);
        keep = last_a + 4;
        q = q[0:keep];
        r = q[keep]; r.rst = 1; q[keep] = r;
        repeat (2) add_reset_rec(1, 0);
        add_reset_rec(0, 1);

        // randomized commands
        for (int c = 0; c < 60; c++) begin
            clear_reads();
            resp_delay = $urandom_range(0, 3);
            m = (($urandom % 6) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
            for (int j = 0; j < MAXP; j++) begin
                rd_wait[j] = $urandom_range(0, 3);
                rd_err[j]  = (($urandom % 10) == 0);
                rd_data[j] = (($urandom % 4) == 0) ? $urandom : ($urandom & ~m);
            end
            repeat ($urandom_range(0, 2)) add_idle();
            add_cmd(1'($urandom % 3 == 0), 1'($urandom % 4 != 0), $urandom, $urandom, m);
        end
        add_idle();

        @(posedge clk); #1;
        while (q.size() > 0) begin
            r = q.pop_front();
            drive(r);
            @(negedge clk);
            check_rec(r);
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
